// File: rtl/ysyx_22040386_pipe_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flushable control field and a saturating stall counter.
module ysyx_22040386_pipe_stage #(
    parameter int unsigned       CTRL_W   = 16,
    parameter int unsigned       DATA_W   = 256,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
    parameter int unsigned       SKID     = 1,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              i_pipe_stage_clk,
    input  logic              i_pipe_stage_rst_n,
    input  logic              i_pipe_stage_flush,
    input  logic              i_pipe_stage_valid,
    output logic              o_pipe_stage_ready,
    input  logic [CTRL_W-1:0] i_pipe_stage_ctrl,
    input  logic [DATA_W-1:0] i_pipe_stage_data,
    output logic              o_pipe_stage_valid,
    input  logic              i_pipe_stage_ready,
    output logic [CTRL_W-1:0] o_pipe_stage_ctrl,
    output logic [DATA_W-1:0] o_pipe_stage_data,
    output logic [CNT_W-1:0]  o_pipe_stage_stall_cnt,
    input  logic              i_pipe_stage_cnt_clr
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              rdy_q, rdy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready;
    logic              in_xfer;
    logic              out_xfer;

    assign ready    = (SKID != 0) ? rdy_q : (i_pipe_stage_ready | ~valid_q);
    assign in_xfer  = i_pipe_stage_valid & ready;
    assign out_xfer = valid_q & i_pipe_stage_ready;

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (i_pipe_stage_flush) begin
            // Data fields are deliberately left alone; only control becomes a bubble.
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            ctrl_d       = CTRL_RST;
            skid_ctrl_d  = CTRL_RST;
        end else if (SKID != 0) begin
            // Skid entry is always older than new input, so it drains first.
            if (out_xfer && skid_valid_q) begin
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer && (!valid_q || out_xfer)) begin
                valid_d = 1'b1;
                ctrl_d  = i_pipe_stage_ctrl;
                data_d  = i_pipe_stage_data;
            end else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = i_pipe_stage_ctrl;
                skid_data_d  = i_pipe_stage_data;
            end else if (out_xfer) begin
                valid_d = 1'b0;
            end
        end else begin
            if (in_xfer) begin
                valid_d = 1'b1;
                ctrl_d  = i_pipe_stage_ctrl;
                data_d  = i_pipe_stage_data;
            end else if (out_xfer) begin
                valid_d = 1'b0;
            end
        end
        rdy_d = ~skid_valid_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_pipe_stage_cnt_clr) begin
            cnt_d = '0;
        end else if (valid_q && !i_pipe_stage_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_pipe_stage_clk or negedge i_pipe_stage_rst_n) begin
        if (!i_pipe_stage_rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= CTRL_RST;
            data_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= CTRL_RST;
            skid_data_q  <= '0;
            rdy_q        <= 1'b1;
            cnt_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            rdy_q        <= rdy_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_pipe_stage_ready     = ready;
    assign o_pipe_stage_valid     = valid_q;
    assign o_pipe_stage_ctrl      = ctrl_q;
    assign o_pipe_stage_data      = data_q;
    assign o_pipe_stage_stall_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_22040386_pipe_stage.sv
// Bench for ysyx_22040386_pipe_stage: a skid instance (4-bit counter) and a SKID=0 instance
// share stimulus; a scoreboard tracks beats through whichever instance is selected.
module tb_ysyx_22040386_pipe_stage;

    localparam int unsigned CW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          cnt_clr = 1'b0;

    logic          s_ready, s_valid, n_ready, n_valid;
    logic [CW-1:0] s_ctrl, n_ctrl;
    logic [DW-1:0] s_data, n_data;
    logic [3:0]    s_cnt;
    logic [15:0]   n_cnt;

    logic          sel = 1'b0;
    logic [CW+DW-1:0] sb_q[$];
    logic [CW+DW-1:0] sb_exp;
    int            chk_cnt = 0;
    int            pass_cnt = 0;

    always #5 clk = ~clk;

    ysyx_22040386_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_skid (
        .i_pipe_stage_clk      (clk),
        .i_pipe_stage_rst_n    (rst_n),
        .i_pipe_stage_flush    (flush),
        .i_pipe_stage_valid    (in_valid),
        .o_pipe_stage_ready    (s_ready),
        .i_pipe_stage_ctrl     (in_ctrl),
        .i_pipe_stage_data     (in_data),
        .o_pipe_stage_valid    (s_valid),
        .i_pipe_stage_ready    (in_ready),
        .o_pipe_stage_ctrl     (s_ctrl),
        .o_pipe_stage_data     (s_data),
        .o_pipe_stage_stall_cnt(s_cnt),
        .i_pipe_stage_cnt_clr  (cnt_clr)
    );

    ysyx_22040386_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_noskid (
        .i_pipe_stage_clk      (clk),
        .i_pipe_stage_rst_n    (rst_n),
        .i_pipe_stage_flush    (flush),
        .i_pipe_stage_valid    (in_valid),
        .o_pipe_stage_ready    (n_ready),
        .i_pipe_stage_ctrl     (in_ctrl),
        .i_pipe_stage_data     (in_data),
        .o_pipe_stage_valid    (n_valid),
        .i_pipe_stage_ready    (in_ready),
        .o_pipe_stage_ctrl     (n_ctrl),
        .o_pipe_stage_data     (n_data),
        .o_pipe_stage_stall_cnt(n_cnt),
        .i_pipe_stage_cnt_clr  (cnt_clr)
    );

    wire          m_valid = sel ? n_valid : s_valid;
    wire          m_ready = sel ? n_ready : s_ready;
    wire [CW-1:0] m_ctrl  = sel ? n_ctrl : s_ctrl;
    wire [DW-1:0] m_data  = sel ? n_data : s_data;

    // Inputs are stable between posedge+1 and the next posedge, so the negedge sees
    // exactly the handshake that the coming edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && in_ready) begin
                chk_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got ctrl=%h data=%h, wanted no output",
                             m_ctrl, m_data);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if ({m_ctrl, m_data} !== sb_exp)
                        $display("FAIL sb_order: got %h_%h want %h", m_ctrl, m_data, sb_exp);
                    else pass_cnt++;
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && m_ready) sb_q.push_back({in_ctrl, in_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_cnt++; if (s_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", s_valid); else pass_cnt++;
        chk_cnt++; if (s_ctrl !== 16'h0) $display("FAIL rst_ctrl: got %h want 0000", s_ctrl); else pass_cnt++;
        chk_cnt++; if (s_data !== 32'h0) $display("FAIL rst_data: got %h want 0", s_data); else pass_cnt++;
        chk_cnt++; if (s_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", s_ready); else pass_cnt++;
        chk_cnt++; if (s_cnt !== 4'd0) $display("FAIL rst_cnt: got %0d want 0", s_cnt); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [CW-1:0] beats [3] = '{16'h0011, 16'h0022, 16'h0033};
        sel = 1'b0;
        in_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_ctrl  = beats[i];
            in_data  = 32'hD000_0000 + 32'(i);
            tick();
            chk_cnt++; if (s_valid !== 1'b1 || s_ctrl !== beats[i])
                $display("FAIL stream_out%0d: got v=%b ctrl=%h want v=1 ctrl=%h", i, s_valid, s_ctrl, beats[i]);
            else pass_cnt++;
            chk_cnt++; if (s_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b want 1", i, s_ready); else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk_cnt++; if (s_cnt !== 4'd0) $display("FAIL stream_cnt: got %0d want 0", s_cnt); else pass_cnt++;
        chk_cnt++; if (sb_q.size() != 0) $display("FAIL stream_drain: got %0d left want 0", sb_q.size()); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        in_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h000A; in_data = 32'hAAAA_0001;
        tick();
        in_ctrl = 16'h000B; in_data = 32'hBBBB_0002;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (s_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", s_ready); else pass_cnt++;
        tick();
        tick();
        chk_cnt++; if (s_ctrl !== 16'h000A) $display("FAIL bp_hold: got %h want 000a", s_ctrl); else pass_cnt++;
        chk_cnt++; if (s_cnt !== 4'd3) $display("FAIL bp_cnt: got %0d want 3", s_cnt); else pass_cnt++;
        in_ready = 1'b1;
        tick();
        chk_cnt++; if (s_valid !== 1'b1 || s_ctrl !== 16'h000B || s_ready !== 1'b1)
            $display("FAIL bp_release: got v=%b ctrl=%h rdy=%b want v=1 ctrl=000b rdy=1", s_valid, s_ctrl, s_ready);
        else pass_cnt++;
        tick();
        chk_cnt++; if (s_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", s_valid); else pass_cnt++;
        chk_cnt++; if (sb_q.size() != 0) $display("FAIL bp_drain: got %0d left want 0", sb_q.size()); else pass_cnt++;
    endtask

    task automatic test_counter();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk_cnt++; if (s_cnt !== 4'd0) $display("FAIL cnt_clr0: got %0d want 0", s_cnt); else pass_cnt++;
        in_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h00C3; in_data = 32'hCCCC_0003;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk_cnt++; if (s_cnt !== 4'd15) $display("FAIL cnt_sat: got %0d want 15", s_cnt); else pass_cnt++;
        tick();
        chk_cnt++; if (s_cnt !== 4'd15) $display("FAIL cnt_sat_hold: got %0d want 15", s_cnt); else pass_cnt++;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk_cnt++; if (s_cnt !== 4'd0) $display("FAIL cnt_clr_prio: got %0d want 0", s_cnt); else pass_cnt++;
        tick();
        chk_cnt++; if (s_cnt !== 4'd1) $display("FAIL cnt_resume: got %0d want 1", s_cnt); else pass_cnt++;
        flush = 1'b1; tick(); flush = 1'b0;
        chk_cnt++; if (s_cnt !== 4'd2 || s_valid !== 1'b0)
            $display("FAIL cnt_flush: got cnt=%0d v=%b want cnt=2 v=0", s_cnt, s_valid);
        else pass_cnt++;
        tick();
        chk_cnt++; if (s_cnt !== 4'd2) $display("FAIL cnt_idle: got %0d want 2", s_cnt); else pass_cnt++;
    endtask

    task automatic test_flush();
        in_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h00A1; in_data = 32'h1111_00A1;
        tick();
        in_ctrl = 16'h00B2; in_data = 32'h2222_00B2;
        tick();
        chk_cnt++; if (s_ready !== 1'b0) $display("FAIL fl_full: got rdy=%b want 0", s_ready); else pass_cnt++;
        flush = 1'b1; in_ctrl = 16'h00FF; in_data = 32'h0000_1234;
        tick();
        flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
        chk_cnt++; if (s_valid !== 1'b0 || s_ctrl !== 16'h0 || s_ready !== 1'b1)
            $display("FAIL fl_state: got v=%b ctrl=%h rdy=%b want v=0 ctrl=0000 rdy=1", s_valid, s_ctrl, s_ready);
        else pass_cnt++;
        chk_cnt++; if (s_data !== 32'h1111_00A1) $display("FAIL fl_data: got %h want 111100a1", s_data); else pass_cnt++;
        tick();
        tick();
        chk_cnt++; if (s_valid !== 1'b0) $display("FAIL fl_nodrain: got %b want 0", s_valid); else pass_cnt++;
        // Flush while empty must still drop a valid&ready input.
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0077;
        tick();
        flush = 1'b0;
        chk_cnt++; if (s_valid !== 1'b0) $display("FAIL fl_drop: got %b want 0", s_valid); else pass_cnt++;
        in_ctrl = 16'h0044; in_data = 32'h4444_0044;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (s_valid !== 1'b1 || s_ctrl !== 16'h0044)
            $display("FAIL fl_resume: got v=%b ctrl=%h want v=1 ctrl=0044", s_valid, s_ctrl);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_async_reset();
        in_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 16'h0099; in_data = 32'h9999_0099;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (s_valid !== 1'b1) $display("FAIL ar_pre: got %b want 1", s_valid); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if (s_valid !== 1'b0 || s_ctrl !== 16'h0 || s_data !== 32'h0)
            $display("FAIL ar_clear: got v=%b ctrl=%h data=%h want 0/0000/0", s_valid, s_ctrl, s_data);
        else pass_cnt++;
        chk_cnt++; if (s_ready !== 1'b1 || s_cnt !== 4'd0)
            $display("FAIL ar_ready_cnt: got rdy=%b cnt=%0d want 1/0", s_ready, s_cnt);
        else pass_cnt++;
        sb_q.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_noskid();
        sel = 1'b1;
        in_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 16'h0051; in_data = 32'h5555_0051;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (n_valid !== 1'b1 || n_ctrl !== 16'h0051)
            $display("FAIL ns_load: got v=%b ctrl=%h want v=1 ctrl=0051", n_valid, n_ctrl);
        else pass_cnt++;
        in_ready = 1'b0;
        #1;
        chk_cnt++; if (n_ready !== 1'b0) $display("FAIL ns_comb_low: got %b want 0", n_ready); else pass_cnt++;
        in_ready = 1'b1;
        #1;
        chk_cnt++; if (n_ready !== 1'b1) $display("FAIL ns_comb_high: got %b want 1", n_ready); else pass_cnt++;
        in_valid = 1'b1; in_ctrl = 16'h0052; in_data = 32'h5555_0052;
        tick();
        in_valid = 1'b0;
        chk_cnt++; if (n_valid !== 1'b1 || n_ctrl !== 16'h0052)
            $display("FAIL ns_replace: got v=%b ctrl=%h want v=1 ctrl=0052", n_valid, n_ctrl);
        else pass_cnt++;
        tick();
        in_ready = 1'b0;
        #1;
        chk_cnt++; if (n_valid !== 1'b0 || n_ready !== 1'b1)
            $display("FAIL ns_empty: got v=%b rdy=%b want v=0 rdy=1", n_valid, n_ready);
        else pass_cnt++;
        chk_cnt++; if (sb_q.size() != 0) $display("FAIL ns_drain: got %0d left want 0", sb_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_counter();
        test_flush();
        test_async_reset();
        test_noskid();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
